seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset. One clock; reset is synchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE or DONE.
REQ-005 SHALL have port A  input  WIDTH  multiplicand; captured on an accepted start.
REQ-006 SHALL have port B  input  WIDTH  multiplier; captured on an accepted start.
REQ-007 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse when Prod holds a new result.
REQ-009 SHALL have port Prod  output  2*WIDTH  product; registered and held until the next result.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE, encoded in registers clocked by clk.
REQ-011 SHALL accept start in IDLE: A and B are latched, the accumulator and step counter are cleared, and the FSM goes to RUN.
REQ-012 SHALL perform one shift-add step per RUN cycle: if the multiplier LSB is 1, add the shifted multiplicand to a 2*WIDTH accumulator; then shift the multiplicand left and the multiplier right.
REQ-013 SHALL stay in RUN for exactly WIDTH cycles, then go to DONE.
REQ-014 SHALL, on entering DONE, load Prod with the accumulator and assert done for exactly one cycle.
REQ-015 SHALL set the latency, from the start-accepting edge to the first cycle with done=1, to exactly WIDTH+1 clocks.
REQ-016 SHALL drive busy=1 in RUN and busy=0 in IDLE and DONE.
REQ-017 SHALL return from DONE to IDLE when start=0; with start=1 in DONE it SHALL accept the new operands and go directly to RUN (back-to-back operation).
REQ-018 SHALL ignore start while in RUN; latched operands and progress SHALL be unaffected.
REQ-019 SHALL ignore changes on A and B after capture.
REQ-020 SHALL compute the exact product with no overflow; the maximum result is (2^WIDTH-1)^2.
REQ-021 SHALL hold Prod constant except on entry to DONE.

Reset
REQ-022 SHALL, with rst_n=0 at a clk edge, force state=IDLE, busy=0, done=0, Prod=0, and clear the accumulator, operand registers and counter.
REQ-023 SHALL, on reset mid-operation, abandon the operation with no done pulse; Prod SHALL read 0.
REQ-024 SHALL take reset priority over start in the same cycle.

Configuration
REQ-025 SHALL, when macro SEQ_MULT_SIGNED_EN is defined, add port sgn (input, 1 bit), sampled with start: sgn=1 treats A and B as two's complement and gives a signed 2*WIDTH Prod; sgn=0 gives unsigned.
REQ-026 SHALL, in signed mode, multiply operand magnitudes and conditionally negate the result on entry to DONE; latency SHALL stay WIDTH+1.
REQ-027 SHALL, when SEQ_MULT_SIGNED_EN is undefined, omit port sgn and operate unsigned only, with no signed logic synthesized.

Verification
REQ-028 SHALL cover, with WIDTH=4: start with A=7, B=9 at edge N -> busy=1 for cycles N+1..N+4, done=1 only at N+5, Prod=8'd63.
REQ-029 SHALL cover: A=15, B=15 -> Prod=8'd225; A=0, B=13 -> Prod=8'd0.
REQ-030 SHALL cover: start pulsed again with A=3, B=3 during RUN of 5*6 -> Prod=8'd30, one done pulse only.
REQ-031 SHALL cover: rst_n=0 two cycles after start of 9*9 -> no done, Prod=0, busy=0; a new 2*3 afterwards -> Prod=6.
REQ-032 SHALL cover: start held high across DONE with operands 4*4 then 2*5 -> done pulses WIDTH+1 cycles apart, Prod=16 then Prod=10.
REQ-033 SHALL cover, with SEQ_MULT_SIGNED_EN and sgn=1: A=4'b1101 (-3), B=5 -> Prod=8'hF1 (-15); A=-8, B=-8 -> Prod=8'd64.

Source files
------------

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: WIDTH RUN cycles, one-cycle done pulse, registered product.
// Optional macro SEQ_MULT_SIGNED_EN adds a 'sgn' port for two's-complement operands.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               sgn,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] Prod
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   sum;
    logic [2*WIDTH-1:0]   result;
    logic                 accept;
    logic                 last_step;
`ifdef SEQ_MULT_SIGNED_EN
    logic                 neg;
    logic                 neg_next;
`endif

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (state == RUN) && (cnt == LAST_STEP);
    assign sum       = acc + (mplier[0] ? mcand : '0);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    // Signed mode works on magnitudes; the most negative value's magnitude fits as unsigned.
`ifdef SEQ_MULT_SIGNED_EN
    assign a_mag    = (sgn && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign b_mag    = (sgn && B[WIDTH-1]) ? (~B + 1'b1) : B;
    assign neg_next = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
    assign result   = neg ? (~sum + 1'b1) : sum;
`else
    assign a_mag  = A;
    assign b_mag  = B;
    assign result = sum;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (cnt == LAST_STEP) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The final step's sum goes straight into Prod so DONE lands WIDTH+1 clocks after start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            Prod   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg    <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (accept) begin
                mcand  <= {{WIDTH{1'b0}}, a_mag};
                mplier <= b_mag;
                acc    <= '0;
                cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                neg    <= neg_next;
`endif
            end else if (state == RUN) begin
                acc    <= sum;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            if (last_step) begin
                Prod <= result;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Table-driven bench for seq_multiplier (WIDTH=4) plus hand-written multi-cycle sequences.
// Signed vectors are added when SEQ_MULT_SIGNED_EN is defined.
module tb_seq_multiplier;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       s;
        logic [7:0] prod;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
`ifdef SEQ_MULT_SIGNED_EN
    logic       sgn;
`endif
    logic       busy;
    logic       done;
    logic [7:0] Prod;

    int pass_cnt  = 0;
    int check_cnt = 0;

    seq_multiplier #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef SEQ_MULT_SIGNED_EN
        .sgn   (sgn),
`endif
        .busy  (busy),
        .done  (done),
        .Prod  (Prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Starts one multiply, scrambles the operand inputs after capture and waits for done.
    task automatic applyStimulus(input vec_t v, output int lat, output int busy_cycles);
        @(negedge clk);
        A     = v.a;
        B     = v.b;
`ifdef SEQ_MULT_SIGNED_EN
        sgn   = v.s;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = ~v.a;
        B     = ~v.b;
        lat   = 1;
        busy_cycles = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        vec_t vecs[$];
        int   lat;
        int   bcyc;
        int   pulses;
        int   first_done;
        int   t1;
        int   t2;
        int   p1;
        int   p2;
        logic [7:0] held;

        vecs.push_back('{4'd7,  4'd9,  1'b0, 8'd63});
        vecs.push_back('{4'd15, 4'd15, 1'b0, 8'd225});
        vecs.push_back('{4'd0,  4'd13, 1'b0, 8'd0});
        vecs.push_back('{4'd13, 4'd0,  1'b0, 8'd0});
        vecs.push_back('{4'd1,  4'd1,  1'b0, 8'd1});
        vecs.push_back('{4'd12, 4'd5,  1'b0, 8'd60});
        vecs.push_back('{4'd15, 4'd1,  1'b0, 8'd15});
        vecs.push_back('{4'd2,  4'd8,  1'b0, 8'd16});
`ifdef SEQ_MULT_SIGNED_EN
        vecs.push_back('{4'b1101, 4'd5,    1'b1, 8'hF1});
        vecs.push_back('{4'b1000, 4'b1000, 1'b1, 8'd64});
        vecs.push_back('{4'd7,    4'b1111, 1'b1, 8'hF9});
        vecs.push_back('{4'b1110, 4'd3,    1'b1, 8'hFA});
        vecs.push_back('{4'd13,   4'd5,    1'b0, 8'd65});
        sgn = 1'b0;
`endif

        rst_n = 1'b0;
        start = 1'b0;
        A     = 4'd0;
        B     = 4'd0;
        repeat (2) @(negedge clk);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset prod", int'(Prod), 0);

        // Reset must win over a simultaneous start.
        A = 4'd7; B = 4'd9; start = 1'b1;
        @(negedge clk);
        checkOutput("reset priority busy", int'(busy), 0);
        start = 1'b0;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], lat, bcyc);
            checkOutput($sformatf("vec%0d latency", i), lat, 5);
            checkOutput($sformatf("vec%0d busy cycles", i), bcyc, 4);
            checkOutput($sformatf("vec%0d prod", i), int'(Prod), int'(vecs[i].prod));
            checkOutput($sformatf("vec%0d busy at done", i), int'(busy), 0);
            held = Prod;
            @(negedge clk);
            checkOutput($sformatf("vec%0d done single", i), int'(done), 0);
            checkOutput($sformatf("vec%0d prod held", i), int'(Prod), int'(held));
        end
`ifdef SEQ_MULT_SIGNED_EN
        sgn = 1'b0;
`endif

        // A second start during RUN is ignored.
        @(negedge clk);
        A = 4'd5; B = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 4'd3; B = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        first_done = 0;
        for (int c = 3; c <= 12; c++) begin
            if (done) begin
                pulses++;
                if (first_done == 0) begin
                    first_done = c;
                    checkOutput("ignore start prod", int'(Prod), 30);
                end
            end
            if (c < 12) @(negedge clk);
        end
        checkOutput("ignore start done cycle", first_done, 5);
        checkOutput("ignore start pulses", pulses, 1);

        // Reset mid-operation abandons the multiply.
        @(negedge clk);
        A = 4'd9; B = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("mid reset busy", int'(busy), 0);
        checkOutput("mid reset done", int'(done), 0);
        checkOutput("mid reset prod", int'(Prod), 0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checkOutput("mid reset no done", pulses, 0);
        applyStimulus('{4'd2, 4'd3, 1'b0, 8'd6}, lat, bcyc);
        checkOutput("after reset latency", lat, 5);
        checkOutput("after reset prod", int'(Prod), 6);

        // Back-to-back: start held across DONE picks up the new operands.
        @(negedge clk);
        @(negedge clk);
        A = 4'd4; B = 4'd4; start = 1'b1;
        @(negedge clk);
        A = 4'd2; B = 4'd5;
        pulses = 0; t1 = 0; t2 = 0; p1 = 0; p2 = 0;
        for (int c = 1; c <= 14; c++) begin
            if (pulses > 0 && start) start = 1'b0;
            if (done) begin
                pulses++;
                if (pulses == 1) begin t1 = c; p1 = int'(Prod); end
                if (pulses == 2) begin t2 = c; p2 = int'(Prod); end
            end
            if (c < 14) @(negedge clk);
        end
        start = 1'b0;
        checkOutput("b2b first done cycle", t1, 5);
        checkOutput("b2b spacing", t2 - t1, 5);
        checkOutput("b2b first prod", p1, 16);
        checkOutput("b2b second prod", p2, 10);
        checkOutput("b2b pulses", pulses, 2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
